branch_ctrl: RTL and testbench

Sequencing controller for the EX-stage branch comparator of the RV32 core. It accepts one branch or jump at a time from decode, waits for forwarded operands, and drives the comparator's 3-bit branch op. It samples the comparator's taken result, computes the redirect target, and issues a registered redirect with a multi-cycle front-end flush. It also keeps saturating branch and taken-branch statistics counters.

---
 rtl/branch_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_branch_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_ctrl.sv
// branch_ctrl -- EX-stage branch sequencing controller.
//
// Accepts one branch/jump at a time from decode, waits for forwarded
// operands, drives the comparator op, resolves taken/not-taken, and issues a
// registered redirect followed by a multi-cycle front-end flush. Keeps
// saturating statistics for conditional branches.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   br_valid/ready    decode handshake (transfer when both high)
//   br_type           00 branch, 01 JAL, 10 JALR, 11 reserved
//   funct3, pc, imm   instruction fields latched on transfer
//   ops_ready         forwarded operands valid this cycle
//   rs1_data          forwarded rs1, JALR base
//   cmp_op/cmp_taken  comparator op out / taken result in
//   stall             holds ID/EX while a branch is in flight
//   redirect_valid/pc one-cycle redirect pulse and target
//   flush             squashes IF/ID for FLUSH_CYCLES cycles
//   misalign          pulse when a taken target has bit 1 set
//   branch_cnt        resolved conditional branches (saturating)
//   taken_cnt         taken conditional branches (saturating)
module branch_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic [1:0]       br_type,
    input  logic [2:0]       funct3,
    input  logic [31:0]      pc,
    input  logic [31:0]      imm,
    input  logic             ops_ready,
    input  logic [31:0]      rs1_data,
    output logic [2:0]       cmp_op,
    input  logic             cmp_taken,
    output logic             stall,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             flush,
    output logic             misalign,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REDIRECT} state_t;
    typedef enum logic [1:0] {BT_BRANCH, BT_JAL, BT_JALR, BT_RSVD} br_type_t;

    state_t           state_q, state_d;
    br_type_t         type_q, type_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      imm_q, imm_d;
    logic [2:0]       flush_cnt_q, flush_cnt_d;
    logic             stall_q, stall_d;
    logic             redirect_valid_q, redirect_valid_d;
    logic [31:0]      redirect_pc_q, redirect_pc_d;
    logic             flush_q, flush_d;
    logic             misalign_q, misalign_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

    logic             resolve;
    logic             taken;
    logic [31:0]      target;

    // JAL needs no operands; everything else waits for forwarding.
    assign resolve = (state_q == S_WAIT) && ((type_q == BT_JAL) || ops_ready);

    always_comb begin
        taken = 1'b0;
        case (type_q)
            BT_BRANCH: taken = cmp_taken;
            BT_JAL:    taken = 1'b1;
            BT_JALR:   taken = 1'b1;
            default:   taken = 1'b0;
        endcase
    end

    assign target = (type_q == BT_JALR) ? ((rs1_data + imm_q) & ~32'h1)
                                        : (pc_q + imm_q);

    always_comb begin
        state_d          = state_q;
        type_d           = type_q;
        funct3_d         = funct3_q;
        pc_d             = pc_q;
        imm_d            = imm_q;
        flush_cnt_d      = flush_cnt_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        misalign_d       = 1'b0;
        branch_cnt_d     = branch_cnt_q;
        taken_cnt_d      = taken_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (br_valid) begin
                    type_d   = br_type_t'(br_type);
                    funct3_d = funct3;
                    pc_d     = pc;
                    imm_d    = imm;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (resolve) begin
                    if (type_q == BT_BRANCH) begin
                        if (branch_cnt_q != '1)
                            branch_cnt_d = branch_cnt_q + CNT_W'(1);
                        if (taken && (taken_cnt_q != '1))
                            taken_cnt_d = taken_cnt_q + CNT_W'(1);
                    end
                    if (!taken) begin
                        state_d = S_IDLE;
                    end else if (target[1]) begin
                        misalign_d = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        redirect_pc_d    = target;
                        redirect_valid_d = 1'b1;
                        flush_cnt_d      = 3'(FLUSH_CYCLES - 1);
                        state_d          = S_REDIRECT;
                    end
                end
            end
            S_REDIRECT: begin
                if (flush_cnt_q == 3'd0)
                    state_d = S_IDLE;
                else
                    flush_cnt_d = flush_cnt_q - 3'd1;
            end
            default: state_d = S_IDLE;
        endcase

        // Registered status follows the state being entered.
        stall_d = (state_d != S_IDLE);
        flush_d = (state_d == S_REDIRECT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            type_q           <= BT_BRANCH;
            funct3_q         <= '0;
            pc_q             <= '0;
            imm_q            <= '0;
            flush_cnt_q      <= '0;
            stall_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            flush_q          <= 1'b0;
            misalign_q       <= 1'b0;
            branch_cnt_q     <= '0;
            taken_cnt_q      <= '0;
        end else begin
            state_q          <= state_d;
            type_q           <= type_d;
            funct3_q         <= funct3_d;
            pc_q             <= pc_d;
            imm_q            <= imm_d;
            flush_cnt_q      <= flush_cnt_d;
            stall_q          <= stall_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            flush_q          <= flush_d;
            misalign_q       <= misalign_d;
            branch_cnt_q     <= branch_cnt_d;
            taken_cnt_q      <= taken_cnt_d;
        end
    end

    assign br_ready       = (state_q == S_IDLE);
    assign cmp_op         = funct3_q;
    assign stall          = stall_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush          = flush_q;
    assign misalign       = misalign_q;
    assign branch_cnt     = branch_cnt_q;
    assign taken_cnt      = taken_cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl. Inputs change 1 time unit after each rising
// edge; outputs are checked in the same window, away from the active edge.
module tb_branch_ctrl;

    localparam int unsigned FC = 2;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          br_valid;
    logic          br_ready;
    logic [1:0]    br_type;
    logic [2:0]    funct3;
    logic [31:0]   pc;
    logic [31:0]   imm;
    logic          ops_ready;
    logic [31:0]   rs1_data;
    logic [2:0]    cmp_op;
    logic          cmp_taken;
    logic          stall;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          flush;
    logic          misalign;
    logic [CW-1:0] branch_cnt;
    logic [CW-1:0] taken_cnt;

    int vectors = 0;
    int miscompares = 0;

    branch_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .br_valid(br_valid), .br_ready(br_ready), .br_type(br_type),
        .funct3(funct3), .pc(pc), .imm(imm),
        .ops_ready(ops_ready), .rs1_data(rs1_data),
        .cmp_op(cmp_op), .cmp_taken(cmp_taken),
        .stall(stall), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .flush(flush), .misalign(misalign),
        .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"},   32'(br_ready),       32'd1);
        chk({tag, "_stall"},   32'(stall),          32'd0);
        chk({tag, "_rv"},      32'(redirect_valid), 32'd0);
        chk({tag, "_flush"},   32'(flush),          32'd0);
        chk({tag, "_misal"},   32'(misalign),       32'd0);
        chk({tag, "_rpc"},     redirect_pc,         32'h0);
        chk({tag, "_cmpop"},   32'(cmp_op),         32'd0);
        chk({tag, "_bcnt"},    32'(branch_cnt),     32'd0);
        chk({tag, "_tcnt"},    32'(taken_cnt),      32'd0);
    endtask

    task automatic present(input logic [1:0] t, input logic [2:0] f3,
                           input logic [31:0] p, input logic [31:0] i);
        br_valid = 1'b1; br_type = t; funct3 = f3; pc = p; imm = i;
    endtask

    initial begin
        rst = 1'b1; br_valid = 1'b0; br_type = 2'b00; funct3 = 3'b000;
        pc = '0; imm = '0; ops_ready = 1'b0; rs1_data = '0; cmp_taken = 1'b0;
        step(); step();
        chk_reset_vals("rst");
        rst = 1'b0;
        step();

        // BEQ not taken
        present(2'b00, 3'b000, 32'h40, 32'h8);
        chk("beq_ready_N", 32'(br_ready), 32'd1);
        step();                                     // N+1
        br_valid = 1'b0; ops_ready = 1'b1; cmp_taken = 1'b0;
        chk("beq_stall", 32'(stall), 32'd1);
        chk("beq_busy", 32'(br_ready), 32'd0);
        chk("beq_cmpop", 32'(cmp_op), 32'd0);
        step();                                     // N+2
        ops_ready = 1'b0;
        chk("beq_ready", 32'(br_ready), 32'd1);
        chk("beq_nostall", 32'(stall), 32'd0);
        chk("beq_rv", 32'(redirect_valid), 32'd0);
        chk("beq_flush", 32'(flush), 32'd0);
        chk("beq_bcnt", 32'(branch_cnt), 32'd1);
        chk("beq_tcnt", 32'(taken_cnt), 32'd0);
        step();

        // BLT taken, backward target; br_valid held during REDIRECT
        present(2'b00, 3'b100, 32'h100, 32'hFFFF_FFF0);
        step();                                     // N+1
        br_valid = 1'b0; ops_ready = 1'b1; cmp_taken = 1'b1;
        chk("blt_cmpop", 32'(cmp_op), 32'd4);
        step();                                     // N+2
        ops_ready = 1'b0; cmp_taken = 1'b0;
        present(2'b01, 3'b000, 32'h700, 32'h4);
        chk("blt_rv", 32'(redirect_valid), 32'd1);
        chk("blt_rpc", redirect_pc, 32'h0000_00F0);
        chk("blt_flush1", 32'(flush), 32'd1);
        chk("blt_busy", 32'(br_ready), 32'd0);
        chk("blt_tcnt", 32'(taken_cnt), 32'd1);
        chk("blt_bcnt", 32'(branch_cnt), 32'd2);
        step();                                     // N+3
        chk("blt_rv_pulse", 32'(redirect_valid), 32'd0);
        chk("blt_flush2", 32'(flush), 32'd1);
        chk("blt_busy2", 32'(br_ready), 32'd0);
        step();                                     // N+4
        br_valid = 1'b0;
        chk("blt_flush_end", 32'(flush), 32'd0);
        chk("blt_ready", 32'(br_ready), 32'd1);
        chk("blt_nostall", 32'(stall), 32'd0);
        step();                                     // N+5
        chk("blt_not_accepted", 32'(stall), 32'd0);

        // JALR misaligned target, operands late 3 cycles
        present(2'b10, 3'b000, 32'h300, 32'h4);
        step();                                     // N+1
        br_valid = 1'b0; ops_ready = 1'b0; rs1_data = 32'h2003;
        step();                                     // N+2
        step();                                     // N+3
        chk("jalr_wait", 32'(stall), 32'd1);
        step();                                     // N+4
        ops_ready = 1'b1;
        chk("jalr_still_wait", 32'(br_ready), 32'd0);
        chk("jalr_no_mis_yet", 32'(misalign), 32'd0);
        step();                                     // N+5
        ops_ready = 1'b0;
        chk("jalr_misalign", 32'(misalign), 32'd1);
        chk("jalr_no_rv", 32'(redirect_valid), 32'd0);
        chk("jalr_no_flush", 32'(flush), 32'd0);
        chk("jalr_ready", 32'(br_ready), 32'd1);
        chk("jalr_rpc_kept", redirect_pc, 32'h0000_00F0);
        step();
        chk("jalr_mis_pulse", 32'(misalign), 32'd0);
        chk("jalr_bcnt", 32'(branch_cnt), 32'd2);

        // JAL wrap-around, ops_ready low throughout
        present(2'b01, 3'b000, 32'hFFFF_FFF8, 32'h10);
        step();                                     // N+1
        br_valid = 1'b0;
        step();                                     // N+2
        chk("jal_rv", 32'(redirect_valid), 32'd1);
        chk("jal_rpc", redirect_pc, 32'h0000_0008);
        chk("jal_bcnt", 32'(branch_cnt), 32'd2);
        chk("jal_tcnt", 32'(taken_cnt), 32'd1);
        step(); step();                             // N+4
        chk("jal_ready", 32'(br_ready), 32'd1);

        // BNE taken, reset during second flush cycle
        present(2'b00, 3'b001, 32'h500, 32'h20);
        step();                                     // N+1
        br_valid = 1'b0; ops_ready = 1'b1; cmp_taken = 1'b1;
        chk("bne_cmpop", 32'(cmp_op), 32'd1);
        step();                                     // N+2
        ops_ready = 1'b0; cmp_taken = 1'b0;
        present(2'b01, 3'b000, 32'h900, 32'h4);
        chk("bne_rpc", redirect_pc, 32'h0000_0520);
        step();                                     // N+3
        chk("bne_flush2", 32'(flush), 32'd1);
        chk("bne_busy", 32'(br_ready), 32'd0);
        rst = 1'b1;
        step();                                     // N+4
        rst = 1'b0; br_valid = 1'b0;
        chk_reset_vals("midrst");
        step();
        chk("midrst_idle", 32'(stall), 32'd0);

        // Counter saturation with 2^CW-1 taken branches, then one more
        for (int unsigned k = 0; k < (1 << CW); k++) begin
            present(2'b00, 3'b000, 32'h0, 32'h8);
            step();
            br_valid = 1'b0; ops_ready = 1'b1; cmp_taken = 1'b1;
            step();
            ops_ready = 1'b0; cmp_taken = 1'b0;
            step(); step();
            if (k == (1 << CW) - 2) begin
                chk("sat_bcnt_pre", 32'(branch_cnt), 32'hF);
                chk("sat_tcnt_pre", 32'(taken_cnt), 32'hF);
            end
        end
        chk("sat_bcnt", 32'(branch_cnt), 32'hF);
        chk("sat_tcnt", 32'(taken_cnt), 32'hF);
        chk("sat_ready", 32'(br_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
